// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the register file, its
// scoreboard and the decode stage.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 5;
    localparam int NUM_RD_DEF   = 3;
    localparam int LINK_REG_IDX = 5;

    // Architectural register names shared with decode
    localparam int REG_ZERO = 0;
    localparam int REG_LINK = LINK_REG_IDX;
    localparam int REG_GP   = 28;
    localparam int REG_SP   = 29;

    // Source selected by a read-port bypass mux
    typedef enum logic [1:0] {
        SRC_ARRAY = 2'd0,
        SRC_WB    = 2'd1,
        SRC_LINK  = 2'd2,
        SRC_ZERO  = 2'd3
    } rd_src_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, same-cycle clear bypass
// for the read ports, and a sticky flag for writebacks nobody issued.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_RD      = NUM_RD_DEF,
    parameter int LINK_REG    = LINK_REG_IDX,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic                     link_valid,
    output logic                     sb_err
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;
    logic            iss_en;
    logic            wb_en;
    logic            link_en;
    logic            sb_err_set;

    // Register 0 never takes part in tracking when it is hard-wired
    assign iss_en  = iss_valid  && !((ZERO_REG_EN != 0) && (iss_addr == '0));
    assign wb_en   = wb_valid   && !((ZERO_REG_EN != 0) && (wb_addr == '0));
    assign link_en = link_valid && !((ZERO_REG_EN != 0) && (LINK_A == '0));

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_en)
            set_vec[iss_addr] = 1'b1;
        if (wb_en)
            clr_vec[wb_addr] = 1'b1;
        if (link_en)
            clr_vec[LINK_A] = 1'b1;
        busy_nxt = set_vec | (busy & ~clr_vec);
    end

    assign sb_err_set = wb_en && !busy[wb_addr] && !(iss_en && (iss_addr == wb_addr));

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
            logic [ADDR_W-1:0] a;
            assign a = rd_addr[k*ADDR_W +: ADDR_W];
            // A same-cycle clear shows through at once; a same-cycle issue waits a cycle
            assign rd_busy[k] = busy[a] && !(clr_vec[a] && !set_vec[a])
                                && !((ZERO_REG_EN != 0) && (a == '0));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (sb_err_set)
                sb_err <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-first bypass, a link write port,
// HI/LO registers and a pending-write scoreboard for RAW hazard detection.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_RD      = NUM_RD_DEF,
    parameter int LINK_REG    = LINK_REG_IDX,
    parameter int ZERO_REG_EN = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     link_valid,
    input  logic [DATA_W-1:0]        link_data,
    input  logic                     hilo_valid,
    input  logic [DATA_W-1:0]        hi_data,
    input  logic [DATA_W-1:0]        lo_data,
    output logic [DATA_W-1:0]        hi_out,
    output logic [DATA_W-1:0]        lo_out,
    output logic                     sb_err
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

    logic [DATA_W-1:0] regs [NREG];
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              wb_en;
    logic              link_en;

    assign wb_en   = wb_valid   && !((ZERO_REG_EN != 0) && (wb_addr == '0));
    assign link_en = link_valid && !((ZERO_REG_EN != 0) && (LINK_A == '0));

    // Link is written after wb so it wins a same-register collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (wb_en)
                regs[wb_addr] <= wb_data;
            if (link_en)
                regs[LINK_A] <= link_data;
            if (hilo_valid) begin
                hi_q <= hi_data;
                lo_q <= lo_data;
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] a;
            rd_src_e           src;
            assign a = rd_addr[k*ADDR_W +: ADDR_W];

            always_comb begin
                src = SRC_ARRAY;
                if ((ZERO_REG_EN != 0) && (a == '0))
                    src = SRC_ZERO;
                else if (link_en && (a == LINK_A))
                    src = SRC_LINK;
                else if (wb_en && (a == wb_addr))
                    src = SRC_WB;
            end

            always_comb begin
                case (src)
                    SRC_ZERO: rd_data[k*DATA_W +: DATA_W] = '0;
                    SRC_LINK: rd_data[k*DATA_W +: DATA_W] = link_data;
                    SRC_WB:   rd_data[k*DATA_W +: DATA_W] = wb_data;
                    default:  rd_data[k*DATA_W +: DATA_W] = regs[a];
                endcase
            end
        end
    endgenerate

    assign hi_out = hilo_valid ? hi_data : hi_q;
    assign lo_out = hilo_valid ? lo_data : lo_q;

    reg_scoreboard #(
        .ADDR_W      (ADDR_W),
        .NUM_RD      (NUM_RD),
        .LINK_REG    (LINK_REG),
        .ZERO_REG_EN (ZERO_REG_EN)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .iss_valid  (iss_valid),
        .iss_addr   (iss_addr),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .link_valid (link_valid),
        .sb_err     (sb_err)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: bypass, scoreboard, link priority, zero
// register, HI/LO and sticky error, with hand-computed expectations.
module tb_reg_file_sb;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     iss_valid;
    logic [ADDR_W-1:0]        iss_addr;
    logic                     wb_valid;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     link_valid;
    logic [DATA_W-1:0]        link_data;
    logic                     hilo_valid;
    logic [DATA_W-1:0]        hi_data;
    logic [DATA_W-1:0]        lo_data;
    logic [DATA_W-1:0]        hi_out;
    logic [DATA_W-1:0]        lo_out;
    logic                     sb_err;

    int total = 0;
    int bad   = 0;

    reg_file_sb #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .LINK_REG(5), .ZERO_REG_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .link_valid(link_valid), .link_data(link_data),
        .hilo_valid(hilo_valid), .hi_data(hi_data), .lo_data(lo_data),
        .hi_out(hi_out), .lo_out(lo_out), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rdp(input int k);
        return rd_data[k*DATA_W +: DATA_W];
    endfunction

    task automatic set_rd(input int k, input logic [ADDR_W-1:0] a);
        rd_addr[k*ADDR_W +: ADDR_W] = a;
    endtask

    // Inputs change on the falling edge; checks happen 1 time unit later
    task automatic next_cycle();
        @(negedge clk);
        iss_valid  = 1'b0;
        wb_valid   = 1'b0;
        link_valid = 1'b0;
        hilo_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_rd(0, 5'd7); set_rd(1, 5'd9); set_rd(2, 5'd5);
        next_cycle(); next_cycle();
        #1;
        for (int k = 0; k < NUM_RD; k++) begin
            total++; if (rdp(k) !== '0) begin bad++; $display("FAIL reset_rd_data%0d got=%h exp=0", k, rdp(k)); end
        end
        total++; if (rd_busy !== 3'b000) begin bad++; $display("FAIL reset_rd_busy got=%b exp=000", rd_busy); end
        total++; if (hi_out !== '0 || lo_out !== '0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi_out, lo_out); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL reset_sb_err got=%b exp=0", sb_err); end
        next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        next_cycle();
        iss_valid = 1'b1; iss_addr = 5'd7;
        next_cycle();
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF; set_rd(0, 5'd7);
        #1;
        total++; if (rdp(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_same got=%h exp=deadbeef", rdp(0)); end
        total++; if (rd_busy[0] !== 1'b0) begin bad++; $display("FAIL bypass_busy_clear got=%b exp=0", rd_busy[0]); end
        next_cycle();
        #1;
        total++; if (rdp(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_stored got=%h exp=deadbeef", rdp(0)); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL bypass_sb_err got=%b exp=0", sb_err); end
    endtask

    task automatic test_scoreboard();
        set_rd(1, 5'd9);
        next_cycle();
        iss_valid = 1'b1; iss_addr = 5'd9;
        #1;
        total++; if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL sb_iss_same got=%b exp=0", rd_busy[1]); end
        next_cycle();
        #1;
        total++; if (rd_busy[1] !== 1'b1) begin bad++; $display("FAIL sb_iss_next got=%b exp=1", rd_busy[1]); end
        next_cycle(); next_cycle();
        #1;
        total++; if (rd_busy[1] !== 1'b1) begin bad++; $display("FAIL sb_hold got=%b exp=1", rd_busy[1]); end
        next_cycle();
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        #1;
        total++; if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL sb_wb_clear got=%b exp=0", rd_busy[1]); end
        total++; if (rdp(1) !== 32'h99) begin bad++; $display("FAIL sb_wb_data got=%h exp=99", rdp(1)); end
        // Issue and writeback together on an idle register
        next_cycle();
        iss_valid = 1'b1; iss_addr = 5'd9; wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hAA;
        #1;
        total++; if (rd_busy[1] !== 1'b0) begin bad++; $display("FAIL sb_isswb_same got=%b exp=0", rd_busy[1]); end
        next_cycle();
        #1;
        total++; if (rd_busy[1] !== 1'b1) begin bad++; $display("FAIL sb_isswb_next got=%b exp=1", rd_busy[1]); end
        total++; if (rdp(1) !== 32'hAA) begin bad++; $display("FAIL sb_isswb_data got=%h exp=aa", rdp(1)); end
        // Issue and writeback together on a busy register: stays busy
        iss_valid = 1'b1; iss_addr = 5'd9; wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hBB;
        #1;
        total++; if (rd_busy[1] !== 1'b1) begin bad++; $display("FAIL sb_busy_isswb got=%b exp=1", rd_busy[1]); end
        next_cycle();
        #1;
        total++; if (rd_busy[1] !== 1'b1) begin bad++; $display("FAIL sb_busy_isswb_next got=%b exp=1", rd_busy[1]); end
        // Re-issue of a busy register is legal
        iss_valid = 1'b1; iss_addr = 5'd9;
        next_cycle();
        wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'hCC;
        next_cycle();
        #1;
        total++; if (rd_busy[1] !== 1'b0 || rdp(1) !== 32'hCC) begin bad++; $display("FAIL sb_final got=%b/%h exp=0/cc", rd_busy[1], rdp(1)); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL sb_no_err got=%b exp=0", sb_err); end
    endtask

    task automatic test_link_collision();
        set_rd(2, 5'd5);
        next_cycle();
        iss_valid = 1'b1; iss_addr = 5'd5;
        next_cycle();
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h11; link_valid = 1'b1; link_data = 32'h22;
        #1;
        total++; if (rdp(2) !== 32'h22) begin bad++; $display("FAIL link_same got=%h exp=22", rdp(2)); end
        total++; if (rd_busy[2] !== 1'b0) begin bad++; $display("FAIL link_busy_same got=%b exp=0", rd_busy[2]); end
        next_cycle();
        #1;
        total++; if (rdp(2) !== 32'h22) begin bad++; $display("FAIL link_stored got=%h exp=22", rdp(2)); end
        total++; if (rd_busy[2] !== 1'b0) begin bad++; $display("FAIL link_busy_next got=%b exp=0", rd_busy[2]); end
        // All three ports read distinct registers at once
        set_rd(0, 5'd7); set_rd(1, 5'd9);
        #1;
        total++; if (rd_data !== {32'h22, 32'hCC, 32'hDEADBEEF}) begin bad++; $display("FAIL multi_port got=%h exp=00000022000000ccdeadbeef", rd_data); end
    endtask

    task automatic test_zero_reg();
        set_rd(0, 5'd0);
        next_cycle();
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF_FFFF; iss_valid = 1'b1; iss_addr = 5'd0;
        #1;
        total++; if (rdp(0) !== '0 || rd_busy[0] !== 1'b0) begin bad++; $display("FAIL zero_same got=%h/%b exp=0/0", rdp(0), rd_busy[0]); end
        next_cycle();
        #1;
        total++; if (rdp(0) !== '0 || rd_busy[0] !== 1'b0) begin bad++; $display("FAIL zero_next got=%h/%b exp=0/0", rdp(0), rd_busy[0]); end
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL zero_sb_err got=%b exp=0", sb_err); end
    endtask

    task automatic test_hilo();
        next_cycle();
        hilo_valid = 1'b1; hi_data = 32'd3; lo_data = 32'd4;
        #1;
        total++; if (hi_out !== 32'd3 || lo_out !== 32'd4) begin bad++; $display("FAIL hilo_same got=%0d/%0d exp=3/4", hi_out, lo_out); end
        next_cycle();
        #1;
        total++; if (hi_out !== 32'd3 || lo_out !== 32'd4) begin bad++; $display("FAIL hilo_stored got=%0d/%0d exp=3/4", hi_out, lo_out); end
        hilo_valid = 1'b1; hi_data = 32'd5; lo_data = 32'd6;
        #1;
        total++; if (hi_out !== 32'd5 || lo_out !== 32'd6) begin bad++; $display("FAIL hilo_bypass got=%0d/%0d exp=5/6", hi_out, lo_out); end
    endtask

    task automatic test_sb_err();
        next_cycle();
        wb_valid = 1'b1; wb_addr = 5'd12; wb_data = 32'h12;
        #1;
        total++; if (sb_err !== 1'b0) begin bad++; $display("FAIL sberr_same got=%b exp=0", sb_err); end
        next_cycle();
        #1;
        total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL sberr_set got=%b exp=1", sb_err); end
        next_cycle(); next_cycle();
        #1;
        total++; if (sb_err !== 1'b1) begin bad++; $display("FAIL sberr_sticky got=%b exp=1", sb_err); end
    endtask

    task automatic test_reset_midrun();
        set_rd(0, 5'd7); set_rd(1, 5'd9); set_rd(2, 5'd5);
        next_cycle();
        iss_valid = 1'b1; iss_addr = 5'd9;
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rd_data !== '0) begin bad++; $display("FAIL mid_reset_data got=%h exp=0", rd_data); end
        total++; if (rd_busy !== 3'b000 || sb_err !== 1'b0) begin bad++; $display("FAIL mid_reset_sb got=%b/%b exp=000/0", rd_busy, sb_err); end
        total++; if (hi_out !== '0 || lo_out !== '0) begin bad++; $display("FAIL mid_reset_hilo got=%h/%h exp=0/0", hi_out, lo_out); end
        next_cycle();
        rst_n = 1'b1;
        iss_valid = 1'b1; iss_addr = 5'd7;
        next_cycle();
        #1;
        total++; if (rd_busy !== 3'b001) begin bad++; $display("FAIL post_reset_busy got=%b exp=001", rd_busy); end
        wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
        next_cycle();
        #1;
        total++; if (rdp(0) !== 32'h77 || sb_err !== 1'b0) begin bad++; $display("FAIL post_reset_wb got=%h/%b exp=77/0", rdp(0), sb_err); end
    endtask

    initial begin
        rst_n = 1'b0; rd_addr = '0;
        iss_valid = 1'b0; iss_addr = '0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        link_valid = 1'b0; link_data = '0;
        hilo_valid = 1'b0; hi_data = '0; lo_data = '0;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_link_collision();
        test_zero_reg();
        test_hilo();
        test_sb_err();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-read-port register file with a pending-write scoreboard, write-first bypass, a dedicated link-register write port and separate HI/LO registers. It sits between decode/issue and writeback in the RISC core and replaces the single-array, unreset, negedge-write register file. It gives issue logic a per-operand busy indication, so RAW hazards are detected in one place.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; 2**ADDR_W architectural registers
- NUM_RD, 3, number of read ports
- LINK_REG, 5, index written by the link port
- ZERO_REG_EN, 1, 1 = register 0 reads 0, ignores writes, is never busy

Ports (all reset values are listed under Operation):
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational, bypassed
- rd_busy  out  NUM_RD  scoreboard busy bit per read address, bypassed
- iss_valid  in  1  mark iss_addr pending this cycle
- iss_addr  in  ADDR_W  destination being issued
- wb_valid  in  1  writeback strobe
- wb_addr  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback value
- link_valid  in  1  write link_data to LINK_REG
- link_data  in  DATA_W  return address
- hilo_valid  in  1  write HI and LO together
- hi_data, lo_data  in  DATA_W  multiply/divide result halves
- hi_out, lo_out  out  DATA_W  current HI/LO, bypassed
- sb_err  out  1  sticky scoreboard-violation flag

## Operation
- Reset (rst_n=0, asynchronous): all registers, HI, LO = 0; all busy bits = 0; sb_err = 0. Consequently rd_data = 0, rd_busy = 0, hi_out = lo_out = 0 during and after reset.
- Writes commit on posedge when enabled.
- If wb and link target the same register in one cycle, link wins.
- Reads are combinational and write-first:
  - If link_valid and rd_addr==LINK_REG, return link_data.
  - Else if wb_valid and rd_addr==wb_addr, return wb_data.
  - Else return the array value.
  - The same write-first rule applies to hi_out/lo_out via hilo_valid.
- ZERO_REG_EN=1: address 0 reads 0; wb/link/iss to address 0 are ignored; rd_busy for address 0 is 0.
- Scoreboard: one busy bit per register.
  - iss_valid sets busy[iss_addr].
  - wb_valid clears busy[wb_addr].
  - link_valid clears busy[LINK_REG].
  - iss and wb to the same address in the same cycle: busy ends set (new issue wins).
  - iss to an already-busy register: busy remains set; this is not an error.
- rd_busy[k] = busy[rd_addr_k], cleared in the same cycle by a matching wb/link that is not also a same-cycle iss. A same-cycle iss does not raise rd_busy until the next cycle.
- sb_err is set on posedge when wb_valid targets a non-zero register that is not busy and is not being issued in the same cycle. It holds until reset.

## Timing
- Write latency: 1 cycle to the array; 0 cycles observed at the read ports via bypass.
- Busy set: visible on rd_busy the cycle after iss_valid.
- Busy clear: visible in the same cycle as wb_valid.
- No handshake, no back-pressure: issue logic stalls on rd_busy.
- Reset deasserted mid-stream: the first posedge after release performs normal writes; there is no pipeline state to flush.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W
  - LINK_REG index constant
  - named register-index constants shared with decode
- Sub-module reg_scoreboard (busy vector, set/clear priority, sb_err) is natural. The data array, HI/LO and bypass muxes stay in the top.

## Test plan
- Reset: hold rst_n=0 mid-run after writes -> all rd_data=0, rd_busy=0, hi_out=lo_out=0, sb_err=0.
- Bypass: wb_valid addr 7 data 0xDEADBEEF with rd_addr0=7 in the same cycle -> rd_data0=0xDEADBEEF that cycle; next cycle, with wb_valid low, it still reads 0xDEADBEEF.
- Scoreboard: iss addr 9 at cycle 0 -> rd_busy=1 at cycle 1; wb addr 9 at cycle 4 -> rd_busy=0 at cycle 4; simultaneous iss+wb to 9 -> busy=1 next cycle.
- Link/wb collision: wb addr 5 = 0x11 and link_data = 0x22 in the same cycle -> reg 5 reads 0x22, busy[5] cleared.
- Zero register: wb addr 0 = 0xFFFF_FFFF, iss addr 0 -> reads 0, rd_busy=0, sb_err stays 0.
- sb_err: wb addr 12 with no prior issue -> sb_err=1 next cycle and remains 1 until rst_n=0; hilo_valid hi=3 lo=4 -> hi_out=3, lo_out=4 the same cycle.
